gate_test_sequencer: RTL

//  Self-checking stimulus controller for a 2-output combinational gate unit (DUT outputs x, y).

---
 rtl/gate_test_sequencer_pkg.sv | 26 ++
 rtl/gate_test_sequencer_settle_timer.sv | 42 ++++
 rtl/gate_test_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gate_test_sequencer_pkg.sv
// gate_seq_pkg
//   Shared definitions for the gate test sequencer:
//   - 3-bit state encoding constants ST_IDLE..ST_DONE and the state_t enum built on them
//   - n_vec(): number of input vectors (2**n_in) for an n_in-input gate
package gate_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_APPLY  = ST_APPLY,
    S_SETTLE = ST_SETTLE,
    S_CHECK  = ST_CHECK,
    S_DONE   = ST_DONE
  } state_t;

  // Number of exhaustive input combinations for an n_in-input gate.
  function automatic int n_vec(input int n_in);
    return 32'sd1 <<< n_in;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// settle_timer
//   Loadable down-counter that times how long a vector is held before the
//   gate outputs are sampled.
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset (count -> 0)
//   load       in   1   load count with load_value (has priority over dec)
//   dec        in   1   decrement by one while count is non-zero
//   load_value in   W   value loaded on load
//   expire     out  1   count == 1, i.e. this is the last settle cycle
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  localparam logic [W-1:0] CNT_ZERO = W'(0);
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic [W-1:0] count_r;

  // Counter register: load wins over decrement, never decrements past zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == CNT_ONE);

endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Exhaustive stimulus/compare controller for a 2-output combinational gate.
//   Steps dut_in through 0..N_VEC-1, holds each vector for SETTLE_CYCLES+2
//   cycles, samples x/y in the CHECK cycle against the EXP_X/EXP_Y truth
//   tables and accumulates per-vector failures.
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   start      in   1       begin a run (only honoured in IDLE or DONE)
//   dut_in     out  N_IN    registered stimulus, MSB = a, LSB = b
//   dut_x      in   1       gate output x (only looked at in CHECK)
//   dut_y      in   1       gate output y (only looked at in CHECK)
//   busy       out  1       run in progress (APPLY/SETTLE/CHECK)
//   done       out  1       run finished, results valid
//   pass       out  1       done with no failing vectors
//   err_count  out  N_IN+1  number of failing vectors
//   fail_vec   out  N_VEC   bit i set if vector i mismatched
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int                     N_IN          = 2,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [n_vec(N_IN)-1:0] EXP_X         = 4'b1000,
  parameter logic [n_vec(N_IN)-1:0] EXP_Y         = 4'b0111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [N_IN-1:0]          dut_in,
  input  logic                     dut_x,
  input  logic                     dut_y,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_count,
  output logic [n_vec(N_IN)-1:0]   fail_vec
);

  localparam int N_VEC = n_vec(N_IN);
  // A zero-cycle settle still needs a legal 1-bit counter.
  localparam int CW    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [N_IN-1:0]  IDX_ZERO    = N_IN'(0);
  localparam logic [N_IN-1:0]  IDX_ONE     = N_IN'(1);
  localparam logic [N_IN-1:0]  IDX_LAST    = N_IN'(N_VEC - 1);
  localparam logic [N_IN:0]    ERR_ZERO    = (N_IN + 1)'(0);
  localparam logic [N_IN:0]    ERR_ONE     = (N_IN + 1)'(1);
  localparam logic [N_VEC-1:0] FAIL_ZERO   = N_VEC'(0);
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES);

  state_t            state_r;
  state_t            next_state_s;
  logic [N_IN-1:0]   idx_r;
  logic [N_IN-1:0]   dut_in_r;
  logic [N_IN:0]     err_count_r;
  logic [N_VEC-1:0]  fail_vec_r;
  logic              mismatch_s;
  logic              timer_load_s;
  logic              timer_dec_s;
  logic              timer_expire_s;
  logic              last_vec_s;

  assign last_vec_s   = (idx_r == IDX_LAST);
  assign timer_load_s = (state_r == S_APPLY);
  assign timer_dec_s  = (state_r == S_SETTLE);

  settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load_s),
    .dec        (timer_dec_s),
    .load_value (SETTLE_LOAD),
    .expire     (timer_expire_s)
  );

  // Compare gated by CHECK so unknown gate outputs elsewhere never reach state.
  always_comb begin
    mismatch_s = 1'b0;
    if (state_r == S_CHECK) begin
      mismatch_s = (dut_x != EXP_X[idx_r]) | (dut_y != EXP_Y[idx_r]);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_APPLY;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_APPLY: begin
        if (SETTLE_CYCLES == 0) begin
          next_state_s = S_CHECK;
        end else begin
          next_state_s = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (timer_expire_s) begin
          next_state_s = S_CHECK;
        end else begin
          next_state_s = S_SETTLE;
        end
      end
      S_CHECK: begin
        if (last_vec_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_APPLY;
        end
      end
      S_DONE: begin
        if (start) begin
          next_state_s = S_APPLY;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Vector index, stimulus and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= IDX_ZERO;
      dut_in_r    <= IDX_ZERO;
      err_count_r <= ERR_ZERO;
      fail_vec_r  <= FAIL_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          // A restart from DONE clears the previous results on the same edge.
          if (start) begin
            idx_r       <= IDX_ZERO;
            dut_in_r    <= IDX_ZERO;
            err_count_r <= ERR_ZERO;
            fail_vec_r  <= FAIL_ZERO;
          end
        end
        S_CHECK: begin
          if (mismatch_s) begin
            fail_vec_r[idx_r] <= 1'b1;
            err_count_r       <= err_count_r + ERR_ONE;
          end
          if (last_vec_s) begin
            dut_in_r <= IDX_ZERO;
          end else begin
            idx_r    <= idx_r + IDX_ONE;
            dut_in_r <= idx_r + IDX_ONE;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign dut_in    = dut_in_r;
  assign err_count = err_count_r;
  assign fail_vec  = fail_vec_r;
  assign busy      = (state_r == S_APPLY) || (state_r == S_SETTLE) || (state_r == S_CHECK);
  assign done      = (state_r == S_DONE);
  assign pass      = (state_r == S_DONE) && (err_count_r == ERR_ZERO);

endmodule
